spi_slave_rx: RTL and testbench
===============================

SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 The block SHALL provide parameter P_DATA_WIDTH, default 16, meaning the number of bits per SPI word (legal range 8..32).
REQ-002 The block SHALL provide parameter P_MSB_FIRST, default 1, meaning MOSI/MISO bit order (1 = MSB first, 0 = LSB first).
REQ-003 The block SHALL provide parameter P_CPHA, default 0, meaning SPI phase (0 = sample on leading edge, 1 = sample on trailing edge; CPOL fixed at 0).
REQ-004 The block SHALL have one clock and a synchronous, active-low reset.
REQ-005 clk  in  1  system clock (CLK_50 domain); all logic on its rising edge.
REQ-006 reset_n  in  1  synchronous active-low reset.
REQ-007 SPI_SCLK  in  1  asynchronous serial clock from the SPI master.
REQ-008 SPI_MOSI  in  1  asynchronous serial data from the master.
REQ-009 SPI_SS_N  in  1  asynchronous active-low slave select.
REQ-010 SPI_MISO  out  1  serial response data.
REQ-011 SPI_MISO_OE  out  1  MISO output enable, high while the slave is selected.
REQ-012 rx_data  out  P_DATA_WIDTH  received word.
REQ-013 rx_valid  out  1  rx_data holds an unconsumed word.
REQ-014 rx_ready  in  1  consumer accepts rx_data when rx_valid && rx_ready.
REQ-015 tx_data  in  P_DATA_WIDTH  response word; sampled at frame start and at each word boundary.
REQ-016 overrun  out  1  one-cycle pulse: a word completed while the holding register was full.
REQ-017 frame_err  out  1  one-cycle pulse: SS_N deasserted mid-word.

Function
REQ-018 SPI_SCLK, SPI_MOSI and SPI_SS_N SHALL each pass through a 2-flop synchronizer; SCLK rising/falling edges SHALL be detected on the synchronized signal; SCLK frequency is at most clk/8.
REQ-019 FSM states SHALL be IDLE and ACTIVE: IDLE->ACTIVE on synchronized SS_N falling; ACTIVE->IDLE on synchronized SS_N rising.
REQ-020 On IDLE->ACTIVE the block SHALL clear the bit counter and load tx_data into the TX shift register.
REQ-021 In ACTIVE, MOSI SHALL be sampled on SCLK rising (P_CPHA=0) or falling (P_CPHA=1) and shifted per P_MSB_FIRST; MISO SHALL advance on the opposite edge.
REQ-022 The bit counter SHALL count 0..P_DATA_WIDTH-1 and wrap to 0; on wrap the word is complete and tx_data is reloaded, so multiple back-to-back words per frame are supported.
REQ-023 rx_valid SHALL assert in the clk cycle after the completing sample edge is detected, with rx_data holding the full word.
REQ-024 rx_valid SHALL remain high, and rx_data stable, until a cycle with rx_ready high.
REQ-025 If a word completes while rx_valid=1 and rx_ready=0, the new word SHALL be dropped, rx_data kept, and overrun pulsed one cycle.
REQ-026 If a word completes in the same cycle that rx_valid && rx_ready, the new word SHALL be loaded, rx_valid stays 1, and no overrun is raised.
REQ-027 SS_N rising with bit counter != 0 SHALL discard the partial word, pulse frame_err one cycle, and clear the counter; rx_valid/rx_data are unaffected.
REQ-028 SCLK edges and MOSI SHALL be ignored in IDLE.
REQ-029 SPI_MISO_OE SHALL equal the inverse of synchronized SS_N; SPI_MISO SHALL be 0 while in IDLE.

Reset
REQ-030 While reset_n=0 at a clk edge: state=IDLE, counter=0, shift registers=0, rx_data=0, rx_valid=0, overrun=0, frame_err=0, SPI_MISO=0, SPI_MISO_OE=0.
REQ-031 Reset asserted mid-frame SHALL abort the frame silently (no frame_err); after release the block SHALL wait for a fresh SS_N falling edge before receiving.

Structure
REQ-032 A shared package rng_spi_pkg SHALL hold the state encoding (IDLE, ACTIVE), the default word width, and the CPHA mode constants.
REQ-033 One sub-module spi_sync_edge SHALL implement the 2-flop synchronizer plus rise/fall edge detection, instantiated once per input (three instances).

Verification
REQ-034 Mode 0, P_DATA_WIDTH=16, rx_ready=1: frame sends 0xA5C3 -> one rx_valid cycle with rx_data=0xA5C3; MISO shifts out tx_data=0x1234 MSB first.
REQ-035 Single frame of two words 0x0001 and 0xFFFF, rx_ready=0 -> rx_data=0x0001 held, overrun pulses once, and rx_data is still 0x0001 after rx_ready rises.
REQ-036 rx_ready pulsed in the exact cycle the second word completes -> rx_data=second word, rx_valid=1, no overrun.
REQ-037 SS_N released after 7 of 16 bits -> frame_err pulses once, no rx_valid; the next full frame 0x5A5A is received correctly.
REQ-038 reset_n low for 1 cycle after bit 9 -> all outputs at reset values, no frame_err; frame after a new SS_N fall decodes 0xBEEF.
REQ-039 P_CPHA=1, P_MSB_FIRST=0, frame 0x00F1 -> rx_data=0x00F1; SCLK at clk/8 with random SS_N setup of 1..3 SCLK periods passes.

Source files
------------

// File: rtl/rng_spi_pkg.sv
// Shared definitions for the SPI slave receiver: FSM encoding, default word
// width and the clock-phase mode constants.
package rng_spi_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

  localparam int unsigned SPI_DEF_DATA_WIDTH = 16;

  // CPHA = 0: sample on the leading (rising) SCLK edge, shift on trailing.
  // CPHA = 1: shift on the leading (rising) SCLK edge, sample on trailing.
  localparam int unsigned SPI_CPHA_LEADING  = 0;
  localparam int unsigned SPI_CPHA_TRAILING = 1;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for one asynchronous input, followed by rise/fall
// detection on the synchronized level. The reset value lets an idle-high
// line (slave select) come out of reset without a spurious edge.
module spi_sync_edge #(
  parameter logic P_RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Metastability stage, synchronized stage and one-cycle history for edges.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_q <= P_RESET_VAL;
      sync_q <= P_RESET_VAL;
      prev_q <= P_RESET_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI slave receiver (CPOL = 0). All SPI pins are oversampled in the clk
// domain; words are collected in a shift register and handed to the consumer
// through a single holding register with a valid/ready handshake. A TX shift
// register returns tx_data on MISO, reloaded at every word boundary so that
// back-to-back words in one frame work.
module spi_slave_rx
  import rng_spi_pkg::*;
#(
  parameter int unsigned P_DATA_WIDTH = SPI_DEF_DATA_WIDTH,
  parameter int unsigned P_MSB_FIRST  = 1,
  parameter int unsigned P_CPHA       = SPI_CPHA_LEADING
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    SPI_SCLK,
  input  logic                    SPI_MOSI,
  input  logic                    SPI_SS_N,
  output logic                    SPI_MISO,
  output logic                    SPI_MISO_OE,
  output logic [P_DATA_WIDTH-1:0] rx_data,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  input  logic [P_DATA_WIDTH-1:0] tx_data,
  output logic                    overrun,
  output logic                    frame_err
);

  localparam int unsigned      CNT_W    = $clog2(P_DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_DATA_WIDTH - 1);

  // Synchronized pins and detected edges
  logic sclk_rise;
  logic sclk_fall;
  logic mosi_sync;
  logic ss_sync;
  logic ss_rise;
  logic ss_fall;
  logic unused_sclk_lvl;
  logic unused_mosi_rise;
  logic unused_mosi_fall;

  // Registered state and next-state
  spi_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [P_DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [P_DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [P_DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    overrun_q, overrun_d;
  logic                    frame_err_q, frame_err_d;

  // Post-reset arming: a frame may only start after slave select has been
  // seen high with the synchronizer flushed, so a reset in mid-frame cannot
  // be followed by a false start on the tail of the aborted frame.
  logic [1:0]              settle_q;
  logic                    armed_q;

  // Combinational helpers
  logic                    sample_edge;
  logic                    shift_edge;
  logic                    word_done;
  logic [P_DATA_WIDTH-1:0] rx_shifted;
  logic [P_DATA_WIDTH-1:0] tx_shifted;
  logic                    miso_bit;

  spi_sync_edge #(.P_RESET_VAL(1'b0)) u_sync_sclk (
    .clk     (clk),
    .reset_n (reset_n),
    .async_i (SPI_SCLK),
    .sync_o  (unused_sclk_lvl),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  spi_sync_edge #(.P_RESET_VAL(1'b0)) u_sync_mosi (
    .clk     (clk),
    .reset_n (reset_n),
    .async_i (SPI_MOSI),
    .sync_o  (mosi_sync),
    .rise_o  (unused_mosi_rise),
    .fall_o  (unused_mosi_fall)
  );

  spi_sync_edge #(.P_RESET_VAL(1'b1)) u_sync_ss (
    .clk     (clk),
    .reset_n (reset_n),
    .async_i (SPI_SS_N),
    .sync_o  (ss_sync),
    .rise_o  (ss_rise),
    .fall_o  (ss_fall)
  );

  // MOSI and SCLK share the same synchronizer depth, so mosi_sync is the
  // level the master drove around the detected SCLK edge.
  assign sample_edge = (P_CPHA == SPI_CPHA_LEADING) ? sclk_rise : sclk_fall;
  assign shift_edge  = (P_CPHA == SPI_CPHA_LEADING) ? sclk_fall : sclk_rise;

  assign rx_shifted = (P_MSB_FIRST != 0) ? {rx_shift_q[P_DATA_WIDTH-2:0], mosi_sync}
                                         : {mosi_sync, rx_shift_q[P_DATA_WIDTH-1:1]};
  assign tx_shifted = (P_MSB_FIRST != 0) ? {tx_shift_q[P_DATA_WIDTH-2:0], 1'b0}
                                         : {1'b0, tx_shift_q[P_DATA_WIDTH-1:1]};
  assign miso_bit   = (P_MSB_FIRST != 0) ? tx_shift_q[P_DATA_WIDTH-1] : tx_shift_q[0];

  // State, counter, shift registers and handshake registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Arm frame reception once SS_N is seen high after the synchronizer settles.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      settle_q <= '0;
      armed_q  <= 1'b0;
    end else begin
      if (settle_q != 2'd3) begin
        settle_q <= settle_q + 2'd1;
      end
      if (settle_q == 2'd3 && ss_sync) begin
        armed_q <= 1'b1;
      end
    end
  end

  // Next-state: frame control, bit counting, shifting and word handoff.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = 1'b0;
    frame_err_d = 1'b0;
    word_done   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ss_fall && armed_q) begin
          state_d    = ST_ACTIVE;
          cnt_d      = '0;
          rx_shift_d = '0;
          tx_shift_d = tx_data;
        end
      end
      ST_ACTIVE: begin
        if (ss_rise) begin
          // End of frame; a nonzero count means a word was cut short.
          state_d     = ST_IDLE;
          cnt_d       = '0;
          frame_err_d = (cnt_q != '0);
        end else begin
          if (sample_edge) begin
            rx_shift_d = rx_shifted;
            if (cnt_q == CNT_LAST) begin
              cnt_d     = '0;
              word_done = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          // A shift edge seen with the counter at zero is the first one of
          // a new word (CPHA=1 leading edge, or CPHA=0 after a wrap), so the
          // next response word is loaded instead of shifting.
          if (shift_edge) begin
            tx_shift_d = (cnt_q == '0) ? tx_data : tx_shifted;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A completed word is accepted if the holding register is empty or is
    // being drained in this same cycle; otherwise it is dropped.
    if (word_done) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = rx_shifted;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  assign SPI_MISO    = (state_q == ST_ACTIVE) & miso_bit;
  assign SPI_MISO_OE = ~ss_sync;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign overrun     = overrun_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: dut0 runs mode 0 MSB-first, dut1 runs CPHA=1
// LSB-first. Both share SCLK/MOSI and have separate slave selects; a
// scoreboard queue per instance holds the words expected on rx_data.
module tb_spi_slave_rx;

  logic        clk;
  logic        reset_n;
  logic        sclk;
  logic        mosi;
  logic        ss0_n, ss1_n;
  logic        miso0, miso1;
  logic        oe0, oe1;
  logic [15:0] rx_data0, rx_data1;
  logic        rx_valid0, rx_valid1;
  logic        rdy0, rdy1;
  logic [15:0] tx0, tx1;
  logic        ovr0, ovr1;
  logic        fe0, fe1;

  int n_chk  = 0;
  int n_fail = 0;
  int ovr0_cnt = 0, fe0_cnt = 0, ovr1_cnt = 0, fe1_cnt = 0;

  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];

  spi_slave_rx #(.P_DATA_WIDTH(16), .P_MSB_FIRST(1), .P_CPHA(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .SPI_SCLK(sclk), .SPI_MOSI(mosi), .SPI_SS_N(ss0_n),
    .SPI_MISO(miso0), .SPI_MISO_OE(oe0), .rx_data(rx_data0), .rx_valid(rx_valid0),
    .rx_ready(rdy0), .tx_data(tx0), .overrun(ovr0), .frame_err(fe0)
  );

  spi_slave_rx #(.P_DATA_WIDTH(16), .P_MSB_FIRST(0), .P_CPHA(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .SPI_SCLK(sclk), .SPI_MOSI(mosi), .SPI_SS_N(ss1_n),
    .SPI_MISO(miso1), .SPI_MISO_OE(oe1), .rx_data(rx_data1), .rx_valid(rx_valid1),
    .rx_ready(rdy1), .tx_data(tx1), .overrun(ovr1), .frame_err(fe1)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard and pulse counters, sampled on the falling clk edge.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (ovr0) ovr0_cnt++;
      if (fe0)  fe0_cnt++;
      if (ovr1) ovr1_cnt++;
      if (fe1)  fe1_cnt++;
      if (rx_valid0 && rdy0) begin
        chk("sb0_word_pending", exp_q0.size() > 0, 1);
        if (exp_q0.size() > 0) chk("sb0_rx_data", rx_data0, exp_q0.pop_front());
      end
      if (rx_valid1 && rdy1) begin
        chk("sb1_word_pending", exp_q1.size() > 0, 1);
        if (exp_q1.size() > 0) chk("sb1_rx_data", rx_data1, exp_q1.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic half_bit();
    repeat (4) @(negedge clk);
  endtask

  task automatic set_rdy0(input logic v);
    @(posedge clk);
    #1 rdy0 = v;
  endtask

  task automatic ss_drive(input int sel, input logic v);
    if (sel == 0) ss0_n = v;
    else          ss1_n = v;
  endtask

  task automatic frame_begin(input int sel, input int setup_halves);
    @(negedge clk);
    sclk = 1'b0;
    ss_drive(sel, 1'b0);
    repeat (setup_halves) half_bit();
    chk("miso_oe_active", (sel == 0) ? oe0 : oe1, 1);
  endtask

  task automatic frame_end(input int sel);
    half_bit();
    ss_drive(sel, 1'b1);
    repeat (4) half_bit();
    chk("miso_oe_idle", (sel == 0) ? oe0 : oe1, 0);
    chk("miso_idle", (sel == 0) ? miso0 : miso1, 0);
  endtask

  // Drives bits first..last of w; sel 0 is mode 0 MSB-first, sel 1 is
  // CPHA=1 LSB-first. MISO is captured on the master's sampling edge.
  task automatic send_bits(input int sel, input logic [15:0] w, input int first,
                           input int last, input bit pulse_rdy, output logic [15:0] miso_w);
    int idx;
    miso_w = '0;
    for (int i = first; i <= last; i++) begin
      idx = (sel == 0) ? 15 - i : i;
      if (sel == 0) begin
        mosi = w[idx];
        half_bit();
        sclk = 1'b1;
        miso_w[idx] = miso0;
        if (pulse_rdy && i == last) begin
          // Completing edge is seen after two sync flops; accept on the
          // third clk edge after SCLK rises.
          @(posedge clk);
          @(posedge clk);
          #1 rdy0 = 1'b1;
          @(posedge clk);
          #1 rdy0 = 1'b0;
          repeat (2) @(negedge clk);
        end else begin
          half_bit();
        end
        sclk = 1'b0;
      end else begin
        sclk = 1'b1;
        mosi = w[idx];
        half_bit();
        sclk = 1'b0;
        miso_w[idx] = miso1;
        half_bit();
      end
    end
  endtask

  initial begin
    logic [15:0] m;
    logic [15:0] w;
    logic [15:0] w2;
    int          base;

    reset_n = 1'b0;
    sclk = 1'b0; mosi = 1'b0;
    ss0_n = 1'b1; ss1_n = 1'b1;
    rdy0 = 1'b1; rdy1 = 1'b1;
    tx0 = '0; tx1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_rx_valid0", rx_valid0, 0);
    chk("rst_rx_data0", rx_data0, 0);
    chk("rst_overrun0", ovr0, 0);
    chk("rst_frame_err0", fe0, 0);
    chk("rst_miso0", miso0, 0);
    chk("rst_oe0", oe0, 0);
    chk("rst_rx_valid1", rx_valid1, 0);
    chk("rst_oe1", oe1, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (10) @(negedge clk);

    // Basic mode-0 word with MISO response.
    tx0 = 16'h1234;
    exp_q0.push_back(16'hA5C3);
    frame_begin(0, 2);
    send_bits(0, 16'hA5C3, 0, 15, 1'b0, m);
    frame_end(0);
    chk("miso0_word", m, 16'h1234);
    chk("sb0_drained_basic", exp_q0.size(), 0);

    // Two-word frame with consumer stalled: second word dropped.
    set_rdy0(1'b0);
    base = ovr0_cnt;
    exp_q0.push_back(16'h0001);
    frame_begin(0, 2);
    send_bits(0, 16'h0001, 0, 15, 1'b0, m);
    send_bits(0, 16'hFFFF, 0, 15, 1'b0, m);
    frame_end(0);
    chk("overrun_once", ovr0_cnt - base, 1);
    chk("hold_valid", rx_valid0, 1);
    chk("hold_data", rx_data0, 16'h0001);
    set_rdy0(1'b1);
    repeat (3) @(negedge clk);
    chk("hold_drained_valid", rx_valid0, 0);
    chk("sb0_drained_overrun", exp_q0.size(), 0);

    // Ready pulsed exactly when the second word completes.
    set_rdy0(1'b0);
    base = ovr0_cnt;
    exp_q0.push_back(16'h1111);
    exp_q0.push_back(16'h2222);
    frame_begin(0, 2);
    send_bits(0, 16'h1111, 0, 15, 1'b0, m);
    send_bits(0, 16'h2222, 0, 15, 1'b1, m);
    frame_end(0);
    chk("same_cycle_no_overrun", ovr0_cnt - base, 0);
    chk("same_cycle_valid", rx_valid0, 1);
    chk("same_cycle_data", rx_data0, 16'h2222);
    chk("same_cycle_sb_left", exp_q0.size(), 1);
    set_rdy0(1'b1);
    repeat (3) @(negedge clk);
    chk("sb0_drained_same_cycle", exp_q0.size(), 0);

    // Frame aborted after 7 bits, then a clean frame.
    base = fe0_cnt;
    frame_begin(0, 2);
    send_bits(0, 16'hFFFF, 0, 6, 1'b0, m);
    frame_end(0);
    chk("frame_err_once", fe0_cnt - base, 1);
    chk("frame_err_no_valid", rx_valid0, 0);
    exp_q0.push_back(16'h5A5A);
    frame_begin(0, 2);
    send_bits(0, 16'h5A5A, 0, 15, 1'b0, m);
    frame_end(0);
    chk("sb0_drained_after_abort", exp_q0.size(), 0);

    // Reset pulse after bit 9 of a frame.
    base = fe0_cnt;
    frame_begin(0, 2);
    send_bits(0, 16'hDEAD, 0, 8, 1'b0, m);
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("midrst_rx_valid", rx_valid0, 0);
    chk("midrst_rx_data", rx_data0, 0);
    chk("midrst_overrun", ovr0, 0);
    chk("midrst_frame_err", fe0, 0);
    chk("midrst_miso", miso0, 0);
    chk("midrst_oe", oe0, 0);
    send_bits(0, 16'hDEAD, 9, 15, 1'b0, m);
    frame_end(0);
    chk("midrst_no_frame_err", fe0_cnt - base, 0);
    exp_q0.push_back(16'hBEEF);
    frame_begin(0, 2);
    send_bits(0, 16'hBEEF, 0, 15, 1'b0, m);
    frame_end(0);
    chk("sb0_drained_after_reset", exp_q0.size(), 0);

    // CPHA=1, LSB-first instance; dut0 sits idle while SCLK toggles.
    tx1 = 16'hC00B;
    exp_q1.push_back(16'h00F1);
    frame_begin(1, 2 * $urandom_range(1, 3));
    send_bits(1, 16'h00F1, 0, 15, 1'b0, m);
    frame_end(1);
    chk("miso1_word", m, 16'hC00B);
    for (int k = 0; k < 3; k++) begin
      w  = 16'($urandom);
      w2 = 16'($urandom);
      tx1 = 16'($urandom);
      exp_q1.push_back(w);
      exp_q1.push_back(w2);
      frame_begin(1, 2 * $urandom_range(1, 3));
      send_bits(1, w, 0, 15, 1'b0, m);
      chk("miso1_rand_w0", m, tx1);
      send_bits(1, w2, 0, 15, 1'b0, m);
      chk("miso1_rand_w1", m, tx1);
      frame_end(1);
    end
    chk("sb1_drained", exp_q1.size(), 0);

    repeat (10) @(negedge clk);
    chk("total_overrun0", ovr0_cnt, 1);
    chk("total_frame_err0", fe0_cnt, 1);
    chk("total_overrun1", ovr1_cnt, 0);
    chk("total_frame_err1", fe1_cnt, 0);
    chk("sb0_final_empty", exp_q0.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
